// File: rtl/bn_stat_pkg.sv
// bn_stat_pkg: shared FSM states and default range-scale constants for the range-BN statistics stage
package bn_stat_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, CALC = 2'd2, DONE = 2'd3} state_e;
  localparam int RS_MB16  = 54;
  localparam int RS_MB32  = 49;
  localparam int RS_MB64  = 44;
  localparam int RS_MB128 = 41;
  // Q8 C(n) ~= 1/(2*sqrt(2*ln n)) for the supported batch sizes
  function automatic int default_range_scale(input int mb);
    return mb == 16 ? RS_MB16 : mb == 32 ? RS_MB32 : mb == 128 ? RS_MB128 : RS_MB64;
  endfunction
endpackage

// File: rtl/range_tracker.sv
// range_tracker: running signed max/min of a sample stream
//   clk, rst_n      clock, async active-low reset
//   load_i          load x_i into both max and min (first sample of a batch)
//   upd_i           fold x_i into the running max/min
//   x_i             signed sample
//   max_o, min_o    running extremes
module range_tracker #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_i,
  input  logic                         upd_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic signed [DATA_WIDTH-1:0] max_o,
  output logic signed [DATA_WIDTH-1:0] min_o
);
  logic signed [DATA_WIDTH-1:0] max_q, min_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      min_q <= '0;
    end else if (load_i) begin
      max_q <= x_i;
      min_q <= x_i;
    end else if (upd_i) begin
      max_q <= x_i > max_q ? x_i : max_q;
      min_q <= x_i < min_q ? x_i : min_q;
    end
  end
  assign max_o = max_q;
  assign min_o = min_q;
endmodule

// File: rtl/range_stat_unit.sv
// range_stat_unit: batch mean and range-based std dev of MINI_BATCH samples
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a batch (IDLE only)
//   x_in, x_valid, x_ready     sample stream, accepted on x_valid && x_ready
//   busy                       not IDLE
//   avg_out, stan_dev_out      results, held until the next DONE
//   valid_avg, valid_stan_dev  one-cycle pulse in DONE
module range_stat_unit
  import bn_stat_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MINI_BATCH  = 64,
  parameter int ADDR_WIDTH  = $clog2(MINI_BATCH),
  parameter int FRAC_BITS   = 8,
  parameter int RANGE_SCALE = default_range_scale(MINI_BATCH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_valid,
  output logic                         x_ready,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] avg_out,
  output logic        [DATA_WIDTH-1:0] stan_dev_out,
  output logic                         valid_avg,
  output logic                         valid_stan_dev
);
  localparam int SW = DATA_WIDTH + ADDR_WIDTH;
  localparam int PW = DATA_WIDTH + 17;
  localparam logic [PW-1:0] SD_MAX = PW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  state_e                       state_q, state_d;
  logic        [ADDR_WIDTH-1:0] cnt_q;
  logic signed [SW-1:0]         sum_q;
  logic signed [DATA_WIDTH-1:0] avg_q, max_v, min_v;
  logic        [DATA_WIDTH-1:0] sd_q, sd_sat;
  logic        [DATA_WIDTH:0]   rng;
  logic        [PW-1:0]         prod, sd;
  logic                         acc, last;
  assign acc  = state_q == ACCUM && x_valid;
  assign last = acc && cnt_q == ADDR_WIDTH'(MINI_BATCH - 1);
  always_comb begin
    state_d        = state_q == IDLE  ? (start ? ACCUM : IDLE) :
                     state_q == ACCUM ? (last ? CALC : ACCUM) :
                     state_q == CALC  ? DONE : IDLE;
    x_ready        = state_q == ACCUM;
    busy           = state_q != IDLE;
    valid_avg      = state_q == DONE;
    valid_stan_dev = state_q == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  range_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_trk (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (acc && cnt_q == '0),
    .upd_i  (acc && cnt_q != '0),
    .x_i    (x_in),
    .max_o  (max_v),
    .min_o  (min_v)
  );
  // max >= min, so the sign-extended difference is a non-negative (DATA_WIDTH+1)-bit value
  assign rng    = {max_v[DATA_WIDTH-1], max_v} - {min_v[DATA_WIDTH-1], min_v};
  assign prod   = PW'(rng) * PW'(RANGE_SCALE);
  assign sd     = prod >> FRAC_BITS;
  assign sd_sat = sd > SD_MAX ? SD_MAX[DATA_WIDTH-1:0] : sd[DATA_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
      avg_q <= '0;
      sd_q  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
        sum_q <= '0;
      end else if (acc) begin
        cnt_q <= cnt_q + 1'b1;
        sum_q <= sum_q + SW'(x_in);
      end
      if (state_q == CALC) begin
        avg_q <= DATA_WIDTH'(sum_q >>> ADDR_WIDTH);
        sd_q  <= sd_sat;
      end
    end
  end
  assign avg_out      = avg_q;
  assign stan_dev_out = sd_q;
endmodule

// File: tb/tb_range_stat_unit.sv
// tb_range_stat_unit: scoreboard bench for range_stat_unit (default scale and a saturating scale)
module tb_range_stat_unit;
  logic        clk = 0, rst_n = 0, start = 0, x_valid = 0;
  logic [15:0] x_in = '0;
  logic        x_ready, busy, valid_avg, valid_stan_dev;
  logic [15:0] avg_out, stan_dev_out;
  logic        s_ready, s_busy, s_vavg, s_vsd;
  logic [15:0] s_avg, s_sd;
  range_stat_unit u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .x_valid(x_valid),
    .x_ready(x_ready), .busy(busy), .avg_out(avg_out), .stan_dev_out(stan_dev_out),
    .valid_avg(valid_avg), .valid_stan_dev(valid_stan_dev)
  );
  range_stat_unit #(.RANGE_SCALE(1024)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .x_valid(x_valid),
    .x_ready(s_ready), .busy(s_busy), .avg_out(s_avg), .stan_dev_out(s_sd),
    .valid_avg(s_vavg), .valid_stan_dev(s_vsd)
  );
  always #5 clk = ~clk;
  typedef struct {logic [15:0] avg, sd, sd_sat;} exp_t;
  exp_t        sb[$];
  exp_t        e_m;
  int          total = 0, bad = 0;
  int          cyc = 0, last_acc_cyc = 0, acc_cnt = 0;
  logic [15:0] hold_avg = '0, hold_sd = '0, hold_sat = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_cnt  = 0;
      hold_avg = '0;
      hold_sd  = '0;
      hold_sat = '0;
    end else begin
      if (x_valid && x_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (valid_avg) begin
        if (sb.size() == 0) check("spurious_pulse", 32'(valid_avg), 0);
        else begin
          e_m = sb.pop_front();
          check("avg", 32'(avg_out), 32'(e_m.avg));
          check("sd", 32'(stan_dev_out), 32'(e_m.sd));
          check("sd_sat", 32'(s_sd), 32'(e_m.sd_sat));
          check("vsd", 32'(valid_stan_dev), 1);
          check("sat_pulse", 32'(s_vavg), 1);
          check("latency", 32'(cyc - last_acc_cyc), 2);
          check("accepts", 32'(acc_cnt), 64);
          hold_avg = e_m.avg;
          hold_sd  = e_m.sd;
          hold_sat = e_m.sd_sat;
          acc_cnt  = 0;
        end
      end else begin
        check("hold_avg", 32'(avg_out), 32'(hold_avg));
        check("hold_sd", 32'(stan_dev_out), 32'(hold_sd));
        check("hold_sat", 32'(s_sd), 32'(hold_sat));
        check("vsd_idle", 32'(valid_stan_dev), 0);
      end
    end
  end
  function automatic exp_t model(input int s[64]);
    int   sum, mx, mn, rng, a, b;
    exp_t e;
    sum = 0; mx = s[0]; mn = s[0];
    for (int i = 0; i < 64; i++) begin
      sum += s[i];
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    rng = mx - mn;
    a = (rng * 44) >> 8;
    b = (rng * 1024) >> 8;
    e.avg    = 16'(sum >>> 6);
    e.sd     = 16'(a > 32767 ? 32767 : a);
    e.sd_sat = 16'(b > 32767 ? 32767 : b);
    return e;
  endfunction
  task automatic run_batch(input int s[64], input bit gaps);
    bit ok;
    int n;
    sb.push_back(model(s));
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 0);
    start = 1; x_valid = 1; x_in = 16'd999;
    @(posedge clk); #1;
    start = 0; x_valid = 0;
    for (int i = 0; i < 64; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        x_valid = 0; x_in = 16'($urandom); start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      x_valid = 1; x_in = 16'(s[i]);
      n = 0;
      do begin
        @(negedge clk); ok = x_ready;
        @(posedge clk); #1;
        n++;
      end while (!ok && n < 20);
      if (!ok) check("accept_timeout", 32'(x_ready), 1);
    end
    start = 0; x_valid = 0;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk); ok = valid_avg;
    end
    if (!ok) check("pulse_timeout", 32'(valid_avg), 1);
  endtask
  int          s[64];
  logic [15:0] r;
  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_avg", 32'(avg_out), 0);
    check("rst_sd", 32'(stan_dev_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(x_ready), 0);
    check("rst_valid", 32'(valid_avg), 0);
    rst_n = 1;
    for (int i = 0; i < 64; i++) s[i] = i;
    run_batch(s, 0);
    for (int i = 0; i < 64; i++) s[i] = -5;
    run_batch(s, 0);
    for (int i = 0; i < 64; i++) s[i] = i < 32 ? 32767 : -32768;
    run_batch(s, 0);
    for (int i = 0; i < 64; i++) s[i] = i;
    run_batch(s, 1);
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 30; i++) begin
      x_valid = 1; x_in = 16'(i * 100);
      @(posedge clk); #1;
    end
    #1 rst_n = 0;
    #1;
    check("arst_avg", 32'(avg_out), 0);
    check("arst_sd", 32'(stan_dev_out), 0);
    check("arst_ready", 32'(x_ready), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(valid_avg), 0);
    x_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 64; i++) s[i] = 7;
    run_batch(s, 0);
    for (int i = 0; i < 64; i++) begin
      r = 16'($urandom);
      s[i] = int'($signed(r));
    end
    run_batch(s, 0);
    for (int i = 0; i < 64; i++) s[i] = i;
    run_batch(s, 0);
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
